// File: rtl/tx_pkt_sched_pkg.sv
// Shared definitions for the TX packet scheduler and the TX engine that consumes its grants.
// Packet-type codes, FSM state encoding, default sizing and the packet-size helper live here.
package tx_pkt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } sched_state_t;

    localparam logic [7:0]  PKT_VIDEO     = 8'h00;
    localparam logic [7:0]  PKT_AUDIO     = 8'h01;
    localparam logic [7:0]  PKT_VIDEO_AUX = 8'h02;

    localparam logic [4:0]  AUDIOMAX_DEF  = 5'd20;
    localparam logic [11:0] AUXSIZE_DEF   = 12'd50;
    localparam logic [15:0] AGE_MAX_DEF   = 16'd2048;
    localparam logic [15:0] TIMEOUT_DEF   = 16'd4000;

    // Largest product is 20 entries * 50 bytes, so 12 bits never overflow.
    function automatic logic [11:0] pkt_bytes(input logic [4:0] n, input logic [11:0] entry_size);
        return entry_size * {7'd0, n};
    endfunction

endpackage

// File: rtl/tx_pkt_sched_if.sv
// Request/ack/done handshake between the scheduler (master) and the TX engine (slave).
interface tx_pkt_sched_if;
    logic        req;
    logic        ack;
    logic        done;
    logic [7:0]  pkt_type;
    logic [4:0]  aux_num;
    logic [11:0] pkt_size;

    modport master (
        output req, pkt_type, aux_num, pkt_size,
        input  ack, done
    );

    modport slave (
        input  req, pkt_type, aux_num, pkt_size,
        output ack, done
    );
endinterface

// File: rtl/tx_pkt_sched_sat_cnt.sv
// 16-bit saturating up-counter with synchronous clear; clear wins over enable.
module sat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] cnt
);
    logic [15:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != 16'hFFFF)) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/tx_pkt_sched.sv
// Arbitrates video, audio and video+aux packets onto a single TX engine, with audio
// starvation aging and an ack-to-done watchdog.
module tx_pkt_sched
    import tx_pkt_sched_pkg::*;
#(
    parameter logic [4:0]  AUDIOMAX = AUDIOMAX_DEF,
    parameter logic [11:0] AUXSIZE  = AUXSIZE_DEF,
    parameter logic [15:0] AGE_MAX  = AGE_MAX_DEF,
    parameter logic [15:0] TIMEOUT  = TIMEOUT_DEF
) (
    input  logic            tx_clk,
    input  logic            sys_rst_n,
    input  logic            sched_en,
    input  logic            pb_en,
    input  logic            vid_empty,
    input  logic            ax_empty,
    input  logic [4:0]      ade_cnt,
    tx_pkt_sched_if.master  eng,
    output logic            timeout_err,
    output logic [15:0]     vid_pkts,
    output logic [15:0]     aud_pkts
);

    sched_state_t state_reg;
    logic         req_reg;
    logic [7:0]   pkt_type_reg;
    logic [4:0]   aux_num_reg;
    logic [11:0]  pkt_size_reg;
    logic         timeout_err_reg;
    logic [15:0]  vid_pkts_reg;
    logic [15:0]  aud_pkts_reg;

    logic         aux_avail;
    logic [4:0]   aud_aux;
    logic         grant_valid;
    logic [7:0]   grant_type;
    logic [4:0]   grant_aux;
    logic         aux_grant;
    logic [15:0]  age_cnt;
    logic [15:0]  timer_cnt;

    // A non-empty aux FIFO that reports zero entries has nothing to send.
    assign aux_avail = !ax_empty && (ade_cnt != 5'd0);
    assign aud_aux   = (ade_cnt > AUDIOMAX) ? AUDIOMAX : ade_cnt;

    always_comb begin
        grant_valid = 1'b0;
        grant_type  = PKT_VIDEO;
        grant_aux   = 5'd0;
        if ((state_reg == IDLE) && sched_en) begin
            if (aux_avail && ((age_cnt >= AGE_MAX) || (ade_cnt >= AUDIOMAX))) begin
                grant_valid = 1'b1;
                grant_type  = PKT_AUDIO;
                grant_aux   = aud_aux;
            end else if (!vid_empty) begin
                grant_valid = 1'b1;
                if (pb_en && aux_avail) begin
                    grant_type = PKT_VIDEO_AUX;
                    grant_aux  = 5'd1;
                end
            end else if (aux_avail) begin
                grant_valid = 1'b1;
                grant_type  = PKT_AUDIO;
                grant_aux   = aud_aux;
            end
        end
    end

    assign aux_grant = grant_valid && (grant_type != PKT_VIDEO);

    // Pending-audio age: frozen while the engine is busy, reset whenever aux data ships.
    sat_cnt u_age (
        .clk   (tx_clk),
        .rst_n (sys_rst_n),
        .clr   (!aux_avail || aux_grant),
        .en    (state_reg != BUSY),
        .cnt   (age_cnt)
    );

    sat_cnt u_timer (
        .clk   (tx_clk),
        .rst_n (sys_rst_n),
        .clr   (state_reg != BUSY),
        .en    (state_reg == BUSY),
        .cnt   (timer_cnt)
    );

    always_ff @(posedge tx_clk) begin
        if (!sys_rst_n) begin
            state_reg       <= IDLE;
            req_reg         <= 1'b0;
            pkt_type_reg    <= '0;
            aux_num_reg     <= '0;
            pkt_size_reg    <= '0;
            timeout_err_reg <= 1'b0;
            vid_pkts_reg    <= '0;
            aud_pkts_reg    <= '0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        pkt_type_reg <= grant_type;
                        aux_num_reg  <= grant_aux;
                        pkt_size_reg <= pkt_bytes(grant_aux, AUXSIZE);
                        req_reg      <= 1'b1;
                        state_reg    <= REQ;
                    end
                end
                REQ: begin
                    if (eng.ack) begin
                        req_reg   <= 1'b0;
                        state_reg <= BUSY;
                        if (pkt_type_reg == PKT_AUDIO) begin
                            aud_pkts_reg <= aud_pkts_reg + 16'd1;
                        end else begin
                            vid_pkts_reg <= vid_pkts_reg + 16'd1;
                        end
                    end
                end
                BUSY: begin
                    // The timer reads TIMEOUT-1 on the TIMEOUT-th busy cycle; done there still wins.
                    if (eng.done) begin
                        state_reg <= IDLE;
                    end else if (timer_cnt == (TIMEOUT - 16'd1)) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign eng.req      = req_reg;
    assign eng.pkt_type = pkt_type_reg;
    assign eng.aux_num  = aux_num_reg;
    assign eng.pkt_size = pkt_size_reg;
    assign timeout_err  = timeout_err_reg;
    assign vid_pkts     = vid_pkts_reg;
    assign aud_pkts     = aud_pkts_reg;

endmodule

// File: tb/tb_tx_pkt_sched.sv
// Directed and randomized bench for tx_pkt_sched; the bench plays the TX engine and
// predicts every grant from a transaction-level model of the arbitration rules.
module tb_tx_pkt_sched;

    localparam int AUDIOMAX = 20;
    localparam int AUXSIZE  = 50;
    localparam int AGE_MAX  = 2048;
    localparam int TIMEOUT  = 4000;

    logic       tx_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       sched_en = 1'b0;
    logic       pb_en = 1'b0;
    logic       vid_empty = 1'b1;
    logic       ax_empty = 1'b1;
    logic [4:0] ade_cnt = 5'd0;
    logic       timeout_err;
    logic [15:0] vid_pkts;
    logic [15:0] aud_pkts;

    tx_pkt_sched_if bus();

    tx_pkt_sched dut (
        .tx_clk      (tx_clk),
        .sys_rst_n   (sys_rst_n),
        .sched_en    (sched_en),
        .pb_en       (pb_en),
        .vid_empty   (vid_empty),
        .ax_empty    (ax_empty),
        .ade_cnt     (ade_cnt),
        .eng         (bus),
        .timeout_err (timeout_err),
        .vid_pkts    (vid_pkts),
        .aud_pkts    (aud_pkts)
    );

    always #5 tx_clk = ~tx_clk;

    int checks = 0;
    int errors = 0;
    int m_age = 0;
    int m_vid = 0;
    int m_aud = 0;
    bit exp_grant;
    int exp_type;
    int exp_aux;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        @(negedge tx_clk);
    endtask

    function automatic bit avail();
        return !ax_empty && (ade_cnt != 5'd0);
    endfunction

    // Age counts non-busy cycles of pending audio and restarts whenever aux data is granted.
    function automatic void age_edge(input bit busy, input bit aux_granted);
        if (!avail() || aux_granted) m_age = 0;
        else if (!busy && m_age < 65535) m_age = m_age + 1;
    endfunction

    function automatic void predict();
        int n_aud;
        n_aud = (int'(ade_cnt) < AUDIOMAX) ? int'(ade_cnt) : AUDIOMAX;
        exp_grant = 1'b1;
        exp_type  = 0;
        exp_aux   = 0;
        if (!sched_en) exp_grant = 1'b0;
        else if (avail() && (m_age >= AGE_MAX || int'(ade_cnt) >= AUDIOMAX)) begin
            exp_type = 1; exp_aux = n_aud;
        end else if (!vid_empty) begin
            if (pb_en && avail()) begin exp_type = 2; exp_aux = 1; end
        end else if (avail()) begin
            exp_type = 1; exp_aux = n_aud;
        end else exp_grant = 1'b0;
    endfunction

    task automatic do_reset(input string tag, input int cycles);
        sys_rst_n = 1'b0;
        repeat (cycles) tick();
        chk({tag, "_req"}, bus.req, 0);
        chk({tag, "_type"}, bus.pkt_type, 0);
        chk({tag, "_aux"}, bus.aux_num, 0);
        chk({tag, "_size"}, bus.pkt_size, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_vid"}, vid_pkts, 0);
        chk({tag, "_aud"}, aud_pkts, 0);
        m_age = 0; m_vid = 0; m_aud = 0;
        sys_rst_n = 1'b1;
    endtask

    // Grant edge, optional REQ dwell (with ignored done / dropped enable), then the ack edge.
    task automatic grant_and_ack(input string tag, input int ack_dly, input bit done_in_req, input bit drop_en);
        predict();
        chk({tag, "_grant_predicted"}, {31'd0, exp_grant}, 1);
        tick();
        age_edge(1'b0, exp_type != 0);
        chk({tag, "_req"}, bus.req, 1);
        chk({tag, "_type"}, bus.pkt_type, exp_type);
        chk({tag, "_aux"}, bus.aux_num, exp_aux);
        chk({tag, "_size"}, bus.pkt_size, exp_aux * AUXSIZE);
        for (int i = 0; i < ack_dly; i++) begin
            if (i == 0 && done_in_req) bus.done = 1'b1;
            if (drop_en) sched_en = 1'b0;
            tick();
            bus.done = 1'b0;
            age_edge(1'b0, 1'b0);
            chk({tag, "_req_hold"}, bus.req, 1);
            chk({tag, "_type_hold"}, bus.pkt_type, exp_type);
            chk({tag, "_size_hold"}, bus.pkt_size, exp_aux * AUXSIZE);
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        age_edge(1'b0, 1'b0);
        if (exp_type == 1) m_aud = (m_aud + 1) % 65536;
        else m_vid = (m_vid + 1) % 65536;
        chk({tag, "_req_drop"}, bus.req, 0);
        chk({tag, "_vid_pkts"}, vid_pkts, m_vid);
        chk({tag, "_aud_pkts"}, aud_pkts, m_aud);
    endtask

    task automatic busy_and_done(input string tag, input int busy_len);
        for (int i = 0; i < busy_len; i++) begin
            tick();
            age_edge(1'b1, 1'b0);
            chk({tag, "_busy_terr"}, timeout_err, 0);
            chk({tag, "_busy_req"}, bus.req, 0);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        age_edge(1'b1, 1'b0);
        chk({tag, "_done_terr"}, timeout_err, 0);
    endtask

    initial begin
        int nvid;
        bus.ack  = 1'b0;
        bus.done = 1'b0;

        do_reset("reset", 2);

        // Video only.
        sched_en = 1'b1; vid_empty = 1'b0; ax_empty = 1'b1; ade_cnt = 5'd0; pb_en = 1'b0;
        grant_and_ack("video", 1, 1'b0, 1'b0);
        busy_and_done("video", 2);
        chk("video_vid_pkts_final", vid_pkts, 1);

        // Piggyback aux on video.
        ax_empty = 1'b0; ade_cnt = 5'd3; pb_en = 1'b1;
        grant_and_ack("piggy", 2, 1'b1, 1'b0);
        busy_and_done("piggy", 1);

        // Aux overflow beats video.
        ade_cnt = 5'd25;
        grant_and_ack("ovf", 0, 1'b0, 1'b0);
        busy_and_done("ovf", 0);

        // Starvation: continuous video holds audio off until its age reaches AGE_MAX.
        sched_en = 1'b1; pb_en = 1'b0; vid_empty = 1'b0; ax_empty = 1'b0; ade_cnt = 5'd4;
        do_reset("starve_rst", 1);
        nvid = 0;
        predict();
        while (exp_type != 1 && nvid < 3000) begin
            grant_and_ack("starve_vid", 0, 1'b0, 1'b0);
            busy_and_done("starve_vid", 0);
            nvid++;
            predict();
        end
        chk("starve_vid_count", vid_pkts, nvid);
        grant_and_ack("starve_aud", 0, 1'b0, 1'b0);
        busy_and_done("starve_aud", 0);

        // Watchdog: no done at all.
        pb_en = 1'b0; vid_empty = 1'b0; ax_empty = 1'b1; ade_cnt = 5'd0;
        grant_and_ack("tmo", 0, 1'b0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            age_edge(1'b1, 1'b0);
            chk("tmo_early", timeout_err, 0);
        end
        tick();
        age_edge(1'b1, 1'b0);
        chk("tmo_pulse", timeout_err, 1);
        chk("tmo_req", bus.req, 0);
        vid_empty = 1'b1;
        tick();
        age_edge(1'b0, 1'b0);
        chk("tmo_pulse_end", timeout_err, 0);
        chk("tmo_idle_req", bus.req, 0);

        // Watchdog: done on the final allowed cycle.
        vid_empty = 1'b0;
        grant_and_ack("tmo_edge", 0, 1'b0, 1'b0);
        busy_and_done("tmo_edge", TIMEOUT - 1);
        vid_empty = 1'b1;
        tick();
        age_edge(1'b0, 1'b0);
        chk("tmo_edge_after", timeout_err, 0);

        // Reset while busy, then a normal grant.
        vid_empty = 1'b0;
        grant_and_ack("rstbusy", 1, 1'b0, 1'b0);
        tick(); age_edge(1'b1, 1'b0);
        tick(); age_edge(1'b1, 1'b0);
        do_reset("rstbusy_rst", 1);
        grant_and_ack("rstbusy_next", 1, 1'b0, 1'b0);
        busy_and_done("rstbusy_next", 1);

        // Randomized traffic.
        repeat (120) begin
            sched_en  = ($urandom_range(0, 7) != 0);
            pb_en     = 1'($urandom_range(0, 1));
            vid_empty = 1'($urandom_range(0, 1));
            ax_empty  = ($urandom_range(0, 2) == 0);
            ade_cnt   = 5'($urandom_range(0, 31));
            predict();
            if (exp_grant) begin
                grant_and_ack("rnd", int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
                busy_and_done("rnd", int'($urandom_range(0, 4)));
            end else begin
                tick();
                age_edge(1'b0, 1'b0);
                chk("rnd_no_grant", bus.req, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
